// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline-boundary skid stages.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipe_pkg;

  // Occupancy-encoded stage state: the encoding doubles as the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } skid_state_t;

  // EX/MEM: 16 addresult + 16 aluresult + 16 regread2 + 1 zero + 4 dest;
  //         ctrl = regwrite, memtoreg, branch, memwrite, memread.
  localparam int EXMEM_DATA_W = 53;
  localparam int EXMEM_CTRL_W = 5;

  // MEM/WB: 16 readdata + 16 aluresult + 4 dest; ctrl = regwrite, memtoreg.
  localparam int MEMWB_DATA_W = 36;
  localparam int MEMWB_CTRL_W = 2;

  // Number of held entries for a given state.
  function automatic logic [1:0] state_occupancy(input skid_state_t s);
    case (s)
      ONE:     return 2'd1;
      TWO:     return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot (ctrl + data) of the skid stage.
// Latency: 1 cycle from load to q_*.
// Backpressure: none; the parent decides when to load or clear.
// Ports: clk, rst (async active-low), load (capture d_*), clr_ctrl (zero
//        ctrl only, wins over load), d_ctrl/d_data in, q_ctrl/q_data out.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = EXMEM_DATA_W,
  parameter int CTRL_W = EXMEM_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr_ctrl,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  // Ctrl bits are side-effect enables, so an invalidated slot must read 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_ctrl <= '0;
    end else if (clr_ctrl) begin
      q_ctrl <= '0;
    end else if (load) begin
      q_ctrl <= d_ctrl;
    end
  end

  // Data path is only ever loaded, never cleared after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_data <= '0;
    end else if (load) begin
      q_data <= d_data;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-boundary register with valid/ready handshake, 2-entry skid buffer and flush.
// Latency: 1 cycle from in_fire to out_* when empty or when the head leaves that cycle.
// Backpressure: registered in_ready drops only while both slots are full; full throughput otherwise.
// Ports: clk, rst (async active-low), flush (sync, discards everything incl. same-cycle input),
//        in_valid/in_ready/in_ctrl/in_data upstream, out_valid/out_ready/out_ctrl/out_data
//        downstream, occupancy (0..2).
// Optional: PIPE_STAGE_SKID_STATS_EN adds saturating stall_cnt and flush_cnt outputs.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = EXMEM_DATA_W,
  parameter int CTRL_W = EXMEM_CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_SKID_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  skid_state_t state, next_state;

  logic              in_fire, out_fire;
  logic              m_load, m_clr, m_from_s;
  logic              s_load, s_clr;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_d_ctrl;
  logic [DATA_W-1:0] m_data, s_data, m_d_data;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    next_state = state;
    m_load     = 1'b0;
    m_clr      = 1'b0;
    m_from_s   = 1'b0;
    s_load     = 1'b0;
    s_clr      = 1'b0;
    if (flush) begin
      // Bubble everything: ctrl zeroed, data left as is, input ignored.
      next_state = EMPTY;
      m_clr      = 1'b1;
      s_clr      = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            next_state = ONE;
            m_load     = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            m_load = 1'b1;
          end else if (in_fire) begin
            next_state = TWO;
            s_load     = 1'b1;
          end else if (out_fire) begin
            next_state = EMPTY;
            m_clr      = 1'b1;
          end
        end
        TWO: begin
          // in_ready is low here, so only the drain path exists.
          if (out_fire) begin
            next_state = ONE;
            m_load     = 1'b1;
            m_from_s   = 1'b1;
            s_clr      = 1'b1;
          end
        end
        default: begin
          next_state = EMPTY;
          m_clr      = 1'b1;
          s_clr      = 1'b1;
        end
      endcase
    end
  end

  assign m_d_ctrl = m_from_s ? s_ctrl : in_ctrl;
  assign m_d_data = m_from_s ? s_data : in_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= next_state;
      in_ready <= (next_state != TWO);
    end
  end

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_slot_m (
    .clk      (clk),
    .rst      (rst),
    .load     (m_load),
    .clr_ctrl (m_clr),
    .d_ctrl   (m_d_ctrl),
    .d_data   (m_d_data),
    .q_ctrl   (m_ctrl),
    .q_data   (m_data)
  );

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_slot_s (
    .clk      (clk),
    .rst      (rst),
    .load     (s_load),
    .clr_ctrl (s_clr),
    .d_ctrl   (in_ctrl),
    .d_data   (in_data),
    .q_ctrl   (s_ctrl),
    .q_data   (s_data)
  );

  assign out_valid = (state != EMPTY);
  assign out_ctrl  = out_valid ? m_ctrl : '0;
  assign out_data  = m_data;
  assign occupancy = state_occupancy(state);

`ifdef PIPE_STAGE_SKID_STATS_EN
  // Saturating event counters; they hold at all-ones once reached.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (in_valid && !in_ready && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (flush && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end
`else
  // Statistics disabled: CNT_W has no effect in this build.
  if (CNT_W > 0) begin : g_no_stats
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid against a queue-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipe_stage_skid;

  localparam int DW = 53;
  localparam int CW = 5;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
`ifdef PIPE_STAGE_SKID_STATS_EN
  logic [NW-1:0] stall_cnt;
  logic [NW-1:0] flush_cnt;
`endif

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_SKID_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a FIFO of at most two entries plus the ready it advertises.
  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  logic          m_rdy;
  logic [NW-1:0] m_stall;
  logic [NW-1:0] m_flush;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rdy   = 1'b1;
    m_stall = '0;
    m_flush = '0;
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    bit inf, outf;
    inf  = in_valid && m_rdy;
    outf = (q.size() > 0) && out_ready;
    if (in_valid && !m_rdy && m_stall != '1) m_stall++;
    if (flush && m_flush != '1) m_flush++;
    if (flush) begin
      q.delete();
    end else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back('{c: in_ctrl, d: in_data});
    end
    m_rdy = (q.size() != 2);
  endtask

  task automatic check_all();
    check("out_valid", out_valid, q.size() > 0);
    check("occupancy", occupancy, q.size());
    check("in_ready", in_ready, m_rdy);
    check("out_ctrl", out_ctrl, (q.size() > 0) ? q[0].c : '0);
    if (q.size() > 0) check("out_data", out_data, q[0].d);
`ifdef PIPE_STAGE_SKID_STATS_EN
    check("stall_cnt", stall_cnt, m_stall);
    check("flush_cnt", flush_cnt, m_flush);
`endif
  endtask

  task automatic drive(input logic v, input logic fl, input logic ordy,
                       input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid  = v;
    flush     = fl;
    out_ready = ordy;
    in_ctrl   = c;
    in_data   = d;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    logic [63:0] r;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    model_reset();

    // Reset values
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_out_data", out_data, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_in_ready", in_ready, 1'b1);
    #10 rst = 1'b1;

    // Bubble control: idle with nonzero in_ctrl
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 5'b10101, 53'h0);
      check("bubble_ctrl", out_ctrl, 0);
    end

    // Streaming 1..8 at full rate
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0, 1'b1, 5'h01, DW'(i));
      check("stream_data", out_data, i);
      check("stream_occ", occupancy, 1);
      check("stream_rdy", in_ready, 1'b1);
    end
    drive(1'b0, 1'b0, 1'b1, 5'h00, 53'h0);

    // Backpressure: two pushes fill both slots, then drain in order
    drive(1'b1, 1'b0, 1'b0, 5'h03, 53'hA);
    drive(1'b1, 1'b0, 1'b0, 5'h03, 53'hB);
    check("bp_occ", occupancy, 2);
    check("bp_rdy", in_ready, 1'b0);
    check("bp_head_a", out_data, 53'hA);
    drive(1'b0, 1'b0, 1'b1, 5'h00, 53'h0);
    check("bp_head_b", out_data, 53'hB);
    check("bp_rdy_back", in_ready, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 5'h00, 53'h0);
    check("bp_drained", out_valid, 1'b0);

    // Flush while full, with input offered
    drive(1'b1, 1'b0, 1'b0, 5'h1F, 53'h1);
    drive(1'b1, 1'b0, 1'b0, 5'h1F, 53'h2);
    drive(1'b1, 1'b1, 1'b0, 5'h1F, 53'hC);
    check("fl_valid", out_valid, 1'b0);
    check("fl_ctrl", out_ctrl, 0);
    check("fl_occ", occupancy, 0);
    check("fl_rdy", in_ready, 1'b1);
    // Flush with one entry and a real same-cycle in_fire
    drive(1'b1, 1'b0, 1'b0, 5'h1F, 53'h7);
    drive(1'b1, 1'b1, 1'b1, 5'h1F, 53'hC);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 5'h00, 53'h0);
      check("fl_no_c", out_valid, 1'b0);
    end

    // Asynchronous reset while full
    drive(1'b1, 1'b0, 1'b0, 5'h1F, 53'h11);
    drive(1'b1, 1'b0, 1'b0, 5'h1F, 53'h22);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_ctrl", out_ctrl, 0);
    check("arst_rdy", in_ready, 1'b1);
    check("arst_occ", occupancy, 0);
    model_reset();
    #10 rst = 1'b1;

`ifdef PIPE_STAGE_SKID_STATS_EN
    // 4 stalled cycles then 2 flush cycles
    drive(1'b1, 1'b0, 1'b0, 5'h01, 53'h31);
    drive(1'b1, 1'b0, 1'b0, 5'h01, 53'h32);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 5'h01, 53'h33);
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, 1'b0, 5'h00, 53'h0);
    check("stats_stall4", stall_cnt, 4);
    check("stats_flush2", flush_cnt, 2);
    // Saturation
    force dut.stall_cnt = '1;
    #1 release dut.stall_cnt;
    m_stall = '1;
    drive(1'b1, 1'b0, 1'b0, 5'h01, 53'h41);
    drive(1'b1, 1'b0, 1'b0, 5'h01, 53'h42);
    drive(1'b1, 1'b0, 1'b0, 5'h01, 53'h43);
    drive(1'b1, 1'b0, 1'b0, 5'h01, 53'h44);
    check("stats_sat", stall_cnt, 16'hFFFF);
`endif

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      r = {$urandom, $urandom};
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 1)), 5'($urandom), r[DW-1:0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
